// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // x0 is hard-wired zero, so it never carries a dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] rd,
                                   input logic             wr_en,
                                   input logic [REG_W-1:0] rs);
    return wr_en && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_sel.sv
// ALU operand bypass select for one source register; Memory beats Writeback.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic             regwrite_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             regwrite_w_i,
  output logic [1:0]       fwd_o
);

  always_comb begin
    if (reg_dep(rd_m_i, regwrite_m_i, rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_dep(rd_w_i, regwrite_w_i, rs_i)) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with a memory-wait watchdog.
// Optional HAZARD_PERF_EN adds 32-bit Stall_Count / Flush_Count performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic [REG_W-1:0] Rs1_E,
  input  logic [REG_W-1:0] Rs2_E,
  input  logic [REG_W-1:0] Rd_E,
  input  logic [REG_W-1:0] Rd_M,
  input  logic [REG_W-1:0] Rd_W,
  input  logic             RegWrite_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic             MemAccess_M,
  input  logic             DMem_Ready,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Stall_W,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             Mem_Timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      Stall_Count,
  output logic [31:0]      Flush_Count
`endif
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic       lw_hz, mem_hz;
  logic       freeze, follow_run;
  logic [1:0] fwd_a, fwd_b;

  assign lw_hz  = ResultSrc_E && (reg_dep(Rd_E, RegWrite_E, Rs1_D) ||
                                  reg_dep(Rd_E, RegWrite_E, Rs2_D));
  assign mem_hz = MemAccess_M && !DMem_Ready;

  forward_sel u_fwd_a (
    .rs_i         (Rs1_E),
    .rd_m_i       (Rd_M),
    .regwrite_m_i (RegWrite_M),
    .rd_w_i       (Rd_W),
    .regwrite_w_i (RegWrite_W),
    .fwd_o        (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs_i         (Rs2_E),
    .rd_m_i       (Rd_M),
    .regwrite_m_i (RegWrite_M),
    .rd_w_i       (Rd_W),
    .regwrite_w_i (RegWrite_W),
    .fwd_o        (fwd_b)
  );

  // freeze: every stage holds. follow_run: normal branch / load-use priority applies.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    follow_run = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_hz) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end else begin
          follow_run = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_hz) begin
          freeze = 1'b1;
          if (wait_cnt_q == CNT_LAST) begin
            state_d = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end
        end else begin
          follow_run = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign mem_timeout_d = mem_timeout_q || (state_d == ST_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Held reset masks every control output, whatever the pipeline registers contain.
  assign Stall_F    = rst && (freeze || (follow_run && !PCSrc_E && lw_hz));
  assign Stall_D    = Stall_F;
  assign Stall_E    = rst && freeze;
  assign Stall_M    = rst && freeze;
  assign Stall_W    = rst && freeze;
  assign Flush_D    = rst && follow_run && PCSrc_E;
  assign Flush_E    = rst && follow_run && (PCSrc_E || lw_hz);
  assign ForwardA_E = rst ? fwd_a : FWD_RF;
  assign ForwardB_E = rst ? fwd_b : FWD_RF;
  assign Mem_Timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, Stall_F};
      flush_cnt_q <= flush_cnt_q + {31'd0, Flush_D};
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a randomized run
// against a consecutive-not-ready-cycle reference model.
module tb_hazard_unit;

  localparam int WT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W;
  logic       ResultSrc_E, PCSrc_E, MemAccess_M, DMem_Ready;
  logic       Stall_F, Stall_D, Stall_E, Stall_M, Stall_W;
  logic       Flush_D, Flush_E, Mem_Timeout;
  logic [1:0] ForwardA_E, ForwardB_E;
`ifdef HAZARD_PERF_EN
  logic [31:0] Stall_Count, Flush_Count;
`endif

  logic [4:0] stall_v;
  assign stall_v = {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.WAIT_TIMEOUT(WT)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .Rs1_E       (Rs1_E),
    .Rs2_E       (Rs2_E),
    .Rd_E        (Rd_E),
    .Rd_M        (Rd_M),
    .Rd_W        (Rd_W),
    .RegWrite_E  (RegWrite_E),
    .RegWrite_M  (RegWrite_M),
    .RegWrite_W  (RegWrite_W),
    .ResultSrc_E (ResultSrc_E),
    .PCSrc_E     (PCSrc_E),
    .MemAccess_M (MemAccess_M),
    .DMem_Ready  (DMem_Ready),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Stall_E     (Stall_E),
    .Stall_M     (Stall_M),
    .Stall_W     (Stall_W),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .Mem_Timeout (Mem_Timeout)
`ifdef HAZARD_PERF_EN
    ,
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] stall;
    logic       fd;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  bit halted;
  int not_ready_run;
  int m_stall_cnt, m_flush_cnt;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    bit mem, lw;
    e = '0;
    if (!rst) return e;
    mem = MemAccess_M && !DMem_Ready;
    lw  = ResultSrc_E && RegWrite_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    e.fa = ref_fwd(Rs1_E);
    e.fb = ref_fwd(Rs2_E);
    if (halted || mem) begin
      e.stall = 5'b11111;
    end else if (PCSrc_E) begin
      e.fd = 1'b1;
      e.fe = 1'b1;
    end else if (lw) begin
      e.stall = 5'b11000;
      e.fe    = 1'b1;
    end
    return e;
  endfunction

  // Advance the model across one rising edge with the inputs held this cycle.
  task automatic model_step(input exp_t e);
    m_stall_cnt += int'(e.stall[4]);
    m_flush_cnt += int'(e.fd);
    if (!halted) begin
      if (MemAccess_M && !DMem_Ready) begin
        not_ready_run++;
        if (not_ready_run >= WT) halted = 1'b1;
      end else begin
        not_ready_run = 0;
      end
    end
  endtask

  task automatic model_reset();
    halted        = 1'b0;
    not_ready_run = 0;
    m_stall_cnt   = 0;
    m_flush_cnt   = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    ResultSrc_E = 0; PCSrc_E = 0; MemAccess_M = 0; DMem_Ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ResultSrc_E = 1; RegWrite_E = 1; Rd_E = 7; Rs2_D = 7;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    set_load_use();
    PCSrc_E = 1; MemAccess_M = 1; DMem_Ready = 0;
    Rs1_E = 5; Rd_M = 5; RegWrite_M = 1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_v, Flush_D, Flush_E} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: stall=%b flush=%b%b required all 0", stall_v, Flush_D, Flush_E);
    end
    checks++;
    if ({ForwardA_E, ForwardB_E} !== 4'b0) begin
      failures++;
      $display("FAIL reset_fwd: fwdA=%b fwdB=%b required 00 00", ForwardA_E, ForwardB_E);
    end
    checks++;
    if (Mem_Timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout: Mem_Timeout=%b required 0", Mem_Timeout);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if ({stall_v, Flush_D, Flush_E} !== 7'b0) begin
      failures++;
      $display("FAIL idle_after_reset: stall=%b flush=%b%b required all 0", stall_v, Flush_D, Flush_E);
    end
  endtask

  task automatic test_forwarding();
    tick();
    idle_inputs();
    Rd_M = 5; RegWrite_M = 1; Rs1_E = 5; Rd_W = 5; RegWrite_W = 1;
    @(negedge clk);
    checks++;
    if (ForwardA_E !== 2'b10) begin
      failures++;
      $display("FAIL fwd_mem_priority: ForwardA_E=%b required 10", ForwardA_E);
    end
    RegWrite_M = 0;
    #1;
    checks++;
    if (ForwardA_E !== 2'b01) begin
      failures++;
      $display("FAIL fwd_wb: ForwardA_E=%b required 01", ForwardA_E);
    end
    RegWrite_M = 1; Rd_M = 0; Rd_W = 0;
    #1;
    checks++;
    if (ForwardA_E !== 2'b00) begin
      failures++;
      $display("FAIL fwd_rd_zero: ForwardA_E=%b required 00", ForwardA_E);
    end
    Rs1_E = 3; Rs2_E = 9; Rd_M = 3; Rd_W = 9;
    #1;
    checks++;
    if ({ForwardA_E, ForwardB_E} !== 4'b1001) begin
      failures++;
      $display("FAIL fwd_independent: fwdA=%b fwdB=%b required 10 01", ForwardA_E, ForwardB_E);
    end
  endtask

  task automatic test_load_use();
    tick();
    idle_inputs();
    set_load_use();
    @(negedge clk);
    checks++;
    if ({stall_v, Flush_D, Flush_E} !== 7'b11000_01) begin
      failures++;
      $display("FAIL load_use_stall: stall=%b flush=%b%b required 11000 01", stall_v, Flush_D, Flush_E);
    end
    tick();
    // Load has moved to Memory, bubble sits in Execute, dependent op now in Execute.
    idle_inputs();
    Rd_M = 7; RegWrite_M = 1; Rs2_E = 7;
    @(negedge clk);
    checks++;
    if ({stall_v, Flush_D, Flush_E} !== 7'b0) begin
      failures++;
      $display("FAIL load_use_one_cycle: stall=%b flush=%b%b required all 0", stall_v, Flush_D, Flush_E);
    end
    checks++;
    if (ForwardB_E !== 2'b10) begin
      failures++;
      $display("FAIL load_use_forward: ForwardB_E=%b required 10", ForwardB_E);
    end
  endtask

  task automatic test_branch_over_load_use();
    tick();
    idle_inputs();
    set_load_use();
    PCSrc_E = 1;
    @(negedge clk);
    checks++;
    if ({stall_v, Flush_D, Flush_E} !== 7'b00000_11) begin
      failures++;
      $display("FAIL branch_over_lw: stall=%b flush=%b%b required 00000 11", stall_v, Flush_D, Flush_E);
    end
  endtask

  task automatic test_mem_wait();
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        idle_inputs();
        MemAccess_M = 1; DMem_Ready = 0; PCSrc_E = 1;
        @(negedge clk);
        checks++;
        if ({stall_v, Flush_D, Flush_E} !== 7'b11111_00) begin
          failures++;
          $display("FAIL mem_wait_cycle%0d: stall=%b flush=%b%b required 11111 00", c, stall_v, Flush_D, Flush_E);
        end
      end
      tick();
      DMem_Ready = 1;
      @(negedge clk);
      checks++;
      if ({stall_v, Flush_D, Flush_E} !== 7'b00000_11) begin
        failures++;
        $display("FAIL mem_wait_release: stall=%b flush=%b%b required 00000 11", stall_v, Flush_D, Flush_E);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({Mem_Timeout, stall_v} !== 6'b0) begin
      failures++;
      $display("FAIL mem_wait_back_to_run: Mem_Timeout=%b stall=%b required 0 00000", Mem_Timeout, stall_v);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int c = 0; c < 2; c++) begin
      tick();
      idle_inputs();
      MemAccess_M = 1; DMem_Ready = 0;
    end
    tick();
    reset_pulse();
    for (int c = 0; c < WT - 1; c++) begin
      MemAccess_M = 1; DMem_Ready = 0;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({Mem_Timeout, stall_v} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_wait: Mem_Timeout=%b stall=%b required 0 00000", Mem_Timeout, stall_v);
    end
  endtask

  task automatic test_timeout();
    tick();
    idle_inputs();
    for (int c = 0; c < WT; c++) begin
      MemAccess_M = 1; DMem_Ready = 0;
      @(negedge clk);
      checks++;
      if (stall_v !== 5'b11111 || Mem_Timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d: stall=%b Mem_Timeout=%b required 11111 0", c, stall_v, Mem_Timeout);
      end
      tick();
    end
    idle_inputs();
    PCSrc_E = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({Mem_Timeout, stall_v, Flush_D, Flush_E} !== 8'b1_11111_00) begin
        failures++;
        $display("FAIL halt_hold%0d: Mem_Timeout=%b stall=%b flush=%b%b required 1 11111 00",
                 c, Mem_Timeout, stall_v, Flush_D, Flush_E);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (Mem_Timeout !== 1'b0) begin
      failures++;
      $display("FAIL halt_async_reset: Mem_Timeout=%b required 0", Mem_Timeout);
    end
    tick();
    rst = 1'b1;
    model_reset();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({Mem_Timeout, stall_v} !== 6'b0) begin
      failures++;
      $display("FAIL halt_reset_run: Mem_Timeout=%b stall=%b required 0 00000", Mem_Timeout, stall_v);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    tick();
    idle_inputs();
    reset_pulse();
    #1;
    checks++;
    if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: Stall_Count=%0d Flush_Count=%0d required 0 0", Stall_Count, Flush_Count);
    end
    for (int k = 0; k < 2; k++) begin
      idle_inputs(); set_load_use(); tick();
      idle_inputs(); tick();
    end
    for (int c = 0; c < 3; c++) begin
      MemAccess_M = 1; DMem_Ready = 0; tick();
    end
    DMem_Ready = 1; tick();
    idle_inputs(); PCSrc_E = 1; tick();
    idle_inputs(); tick();
    @(negedge clk);
    checks++;
    if (Stall_Count !== 32'd5) begin
      failures++;
      $display("FAIL perf_stall_count: Stall_Count=%0d required 5", Stall_Count);
    end
    checks++;
    if (Flush_Count !== 32'd1) begin
      failures++;
      $display("FAIL perf_flush_count: Flush_Count=%0d required 1", Flush_Count);
    end
  endtask
`endif

  task automatic test_random();
    exp_t e;
    tick();
    idle_inputs();
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
      Rd_W  = 5'($urandom_range(0, 3));
      RegWrite_E  = 1'($urandom_range(0, 1));
      RegWrite_M  = 1'($urandom_range(0, 1));
      RegWrite_W  = 1'($urandom_range(0, 1));
      ResultSrc_E = ($urandom_range(0, 3) == 0);
      PCSrc_E     = ($urandom_range(0, 6) == 0);
      MemAccess_M = ($urandom_range(0, 4) < 2);
      DMem_Ready  = ($urandom_range(0, 4) < 3);
      @(negedge clk);
      e = model_eval();
      checks++;
      if ({stall_v, Flush_D, Flush_E} !== {e.stall, e.fd, e.fe}) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: stall=%b flush=%b%b required %b %b%b",
                 i, stall_v, Flush_D, Flush_E, e.stall, e.fd, e.fe);
      end
      checks++;
      if ({ForwardA_E, ForwardB_E} !== {e.fa, e.fb}) begin
        failures++;
        $display("FAIL rand_fwd[%0d]: fwdA=%b fwdB=%b required %b %b", i, ForwardA_E, ForwardB_E, e.fa, e.fb);
      end
      checks++;
      if (Mem_Timeout !== halted) begin
        failures++;
        $display("FAIL rand_timeout[%0d]: Mem_Timeout=%b required %b", i, Mem_Timeout, halted);
      end
      @(posedge clk);
      model_step(e);
      #1;
      if (halted) begin
        @(negedge clk);
        checks++;
        if (Mem_Timeout !== 1'b1) begin
          failures++;
          $display("FAIL rand_halt_entry[%0d]: Mem_Timeout=%b required 1", i, Mem_Timeout);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (Stall_Count !== 32'(m_stall_cnt) || Flush_Count !== 32'(m_flush_cnt)) begin
          failures++;
          $display("FAIL rand_perf_halt[%0d]: stall_cnt=%0d flush_cnt=%0d required %0d %0d",
                   i, Stall_Count, Flush_Count, m_stall_cnt, m_flush_cnt);
        end
`endif
        tick();
        reset_pulse();
      end
    end
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    checks++;
    if (Stall_Count !== 32'(m_stall_cnt) || Flush_Count !== 32'(m_flush_cnt)) begin
      failures++;
      $display("FAIL rand_perf: stall_cnt=%0d flush_cnt=%0d required %0d %0d",
               Stall_Count, Flush_Count, m_stall_cnt, m_flush_cnt);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_load_use();
    test_mem_wait();
    test_reset_mid_wait();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
